// File: rtl/jk_count_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_count_ctrl_if
// Purpose  : Command channel for jk_count_ctrl. Carries one valid/ready
//            handshake plus the command payload (direction, start, limit).
// Ports    : (interface signals)
//            cmd_valid  master->slave  command present
//            cmd_ready  slave->master  command accepted when valid & ready
//            cmd_up     master->slave  1 = count up, 0 = count down
//            cmd_start  master->slave  value loaded before counting
//            cmd_limit  master->slave  terminal value
// Revision : 1.0  initial release
// ============================================================================
interface jk_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_up;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_limit;

    // Command issuer.
    modport master (
        output cmd_valid,
        output cmd_up,
        output cmd_start,
        output cmd_limit,
        input  cmd_ready
    );

    // Counter sequencer.
    modport slave (
        input  cmd_valid,
        input  cmd_up,
        input  cmd_start,
        input  cmd_limit,
        output cmd_ready
    );
endinterface : jk_count_ctrl_if
`default_nettype wire

// File: rtl/jk_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_count_ctrl
// Purpose  : Sequencer for a bank of WIDTH jk flip-flops wired as a counter.
//            Accepts a command (load start, count up/down to limit, pulse
//            done) and drives every per-bit j/k pair from the fed-back q.
//            Also clears the bank during reset, since the flops have none.
// Config   : JKC_PAUSE_EN - when defined, adds input pause_i which stalls
//            the bank while counting (RUN). Undefined: no pause port.
// Ports    : clk        rising-edge clock shared with the jk bank
//            rst        synchronous reset, active-high
//            cmd_if     command channel (slave modport)
//            abort_i    abandon the current command (LOAD/RUN only)
//            pause_i    hold the bank in RUN (JKC_PAUSE_EN only)
//            q_i        current flop outputs, bit i from flop i
//            j_o, k_o   per-bit j/k inputs to the flop bank
//            busy_o     high in LOAD and RUN
//            done_o     one-cycle pulse after the limit is reached
// Revision : 1.0  initial release
// ============================================================================
module jk_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    jk_count_ctrl_if.slave        cmd_if,
    input  wire logic             abort_i,
`ifdef JKC_PAUSE_EN
    input  wire logic             pause_i,
`endif
    input  wire logic [WIDTH-1:0] q_i,
    output logic      [WIDTH-1:0] j_o,
    output logic      [WIDTH-1:0] k_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             up_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] limit_q;

    logic             w_ready;
    logic             w_accept;
    logic             w_pause;
    logic [WIDTH-1:0] w_tgl_up;
    logic [WIDTH-1:0] w_tgl_dn;

`ifdef JKC_PAUSE_EN
    assign w_pause = pause_i;
`else
    assign w_pause = 1'b0;
`endif

    // Toggle masks for a synchronous counter built from jk flops: bit i
    // flips when every lower bit is 1 (up) or every lower bit is 0 (down).
    assign w_tgl_up[0] = 1'b1;
    assign w_tgl_dn[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tgl
            assign w_tgl_up[gi] = &q_i[gi-1:0];
            assign w_tgl_dn[gi] = &(~q_i[gi-1:0]);
        end
    endgenerate

    assign cmd_if.cmd_ready = w_ready;
    assign w_accept         = w_ready & cmd_if.cmd_valid;

    // ------------------------------------------------------------------
    // State and command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            up_q    <= 1'b0;
            start_q <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                up_q    <= cmd_if.cmd_up;
                start_q <= cmd_if.cmd_start;
                limit_q <= cmd_if.cmd_limit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. j=k=0 is "hold" for a jk flop, so that is
    // the default drive everywhere except reset, LOAD and active counting.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        j_o     = '0;
        k_o     = '0;
        w_ready = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;

        if (rst) begin
            // j=0, k=1 clears every flop at the reset edge.
            k_o     = '1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort is meaningless here; a command is taken regardless.
                    w_ready = 1'b1;
                    if (cmd_if.cmd_valid) begin
                        state_d = S_LOAD;
                    end
                end

                S_LOAD: begin
                    busy_o = 1'b1;
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end else begin
                        // j=1,k=0 sets; j=0,k=1 clears: forces q to start.
                        j_o     = start_q;
                        k_o     = ~start_q;
                        state_d = S_RUN;
                    end
                end

                S_RUN: begin
                    busy_o = 1'b1;
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end else if (w_pause) begin
                        state_d = S_RUN;
                    end else if (q_i == limit_q) begin
                        state_d = S_DONE;
                    end else begin
                        j_o = up_q ? w_tgl_up : w_tgl_dn;
                        k_o = up_q ? w_tgl_up : w_tgl_dn;
                    end
                end

                S_DONE: begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule : jk_count_ctrl
`default_nettype wire

// File: tb/tb_jk_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_count_ctrl
// Purpose  : Self-checking bench for jk_count_ctrl (WIDTH=4). Models the jk
//            flop bank as the plant and predicts the counter value with plain
//            modular arithmetic. Define JKC_PAUSE_EN to cover the pause input.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_count_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
`ifdef JKC_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    jk_count_ctrl_if #(.WIDTH(WIDTH)) cmd_if ();

    jk_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_if  (cmd_if.slave),
        .abort_i (abort),
`ifdef JKC_PAUSE_EN
        .pause_i (pause),
`endif
        .q_i     (q),
        .j_o     (j),
        .k_o     (k),
        .busy_o  (busy),
        .done_o  (done)
    );

    // The jk flop bank: j&k toggles, j sets, k clears, neither holds.
    always @(posedge clk) begin
        q <= (j & ~q) | (~k & q);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to completion, predicting q each cycle.
    // abort_k / pause_k index RUN cycles after q first equals start (-1: never).
    task automatic run_cmd(input logic up, input logic [3:0] start, input logic [3:0] limit,
                           input int abort_k, input int pause_k, input int pause_len);
        logic [3:0] cur;
        logic       ab;
        logic       pz;
        bit         finished;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_up    = up;
        cmd_if.cmd_start = start;
        cmd_if.cmd_limit = limit;
        #1;
        n_total++;
        if (cmd_if.cmd_ready !== 1'b1)
            $display("FAIL accept_ready: got %b expected 1", cmd_if.cmd_ready);
        else n_pass++;
        step();
        // Scramble the payload: the DUT must have latched it.
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_start = 4'($urandom);
        cmd_if.cmd_limit = 4'($urandom);
        cmd_if.cmd_up    = 1'($urandom);
        n_total++;
        if ({busy, done} !== 2'b10)
            $display("FAIL load_flags: got busy/done=%b expected 10", {busy, done});
        else n_pass++;
        step();
        cur = start;
        n_total++;
        if ({q, busy, done} !== {cur, 2'b10})
            $display("FAIL first_value: got q=%0d busy/done=%b expected q=%0d 10", q, {busy, done}, cur);
        else n_pass++;
        finished = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ab = (c == abort_k);
`ifdef JKC_PAUSE_EN
            pz = (c >= pause_k) && (c < pause_k + pause_len);
            pause = pz;
`else
            pz = 1'b0;
`endif
            abort = ab;
            step();
            abort = 1'b0;
`ifdef JKC_PAUSE_EN
            pause = 1'b0;
`endif
            if (ab) begin
                n_total++;
                if ({q, busy, done, cmd_if.cmd_ready} !== {cur, 3'b001})
                    $display("FAIL abort_state: got q=%0d b/d/r=%b expected q=%0d 001", q, {busy, done, cmd_if.cmd_ready}, cur);
                else n_pass++;
                finished = 1'b1;
                break;
            end else if (pz) begin
                n_total++;
                if ({q, busy, done} !== {cur, 2'b10})
                    $display("FAIL pause_hold: got q=%0d busy/done=%b expected q=%0d 10", q, {busy, done}, cur);
                else n_pass++;
            end else if (cur == limit) begin
                n_total++;
                if ({q, busy, done} !== {cur, 2'b01})
                    $display("FAIL done_pulse: got q=%0d busy/done=%b expected q=%0d 01", q, {busy, done}, cur);
                else n_pass++;
                step();
                n_total++;
                if ({q, busy, done, cmd_if.cmd_ready} !== {cur, 3'b001})
                    $display("FAIL back_idle: got q=%0d b/d/r=%b expected q=%0d 001", q, {busy, done, cmd_if.cmd_ready}, cur);
                else n_pass++;
                finished = 1'b1;
                break;
            end else begin
                cur = up ? cur + 4'd1 : cur - 4'd1;
                n_total++;
                if ({q, busy, done} !== {cur, 2'b10})
                    $display("FAIL count_value: got q=%0d busy/done=%b expected q=%0d 10", q, {busy, done}, cur);
                else n_pass++;
            end
        end
        if (!finished) begin
            n_total++;
            $display("FAIL cmd_timeout: got no completion expected done or abort within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        abort            = 1'b0;
`ifdef JKC_PAUSE_EN
        pause            = 1'b0;
`endif
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_up    = 1'b0;
        cmd_if.cmd_start = '0;
        cmd_if.cmd_limit = '0;
        #1;
        n_total++;
        if ({cmd_if.cmd_ready, busy, done} !== 3'b000)
            $display("FAIL reset_flags: got r/b/d=%b expected 000", {cmd_if.cmd_ready, busy, done});
        else n_pass++;
        step();
        step();
        rst = 1'b0;
        #1;
        n_total++;
        if ({q, cmd_if.cmd_ready, busy, done} !== {4'd0, 3'b100})
            $display("FAIL powerup_state: got q=%0d r/b/d=%b expected q=0 100", q, {cmd_if.cmd_ready, busy, done});
        else n_pass++;
        // Put 1011 into the bank, then reset over it.
        run_cmd(1'b1, 4'b1011, 4'b1011, -1, -1, 0);
        rst = 1'b1;
        #1;
        n_total++;
        if ({j, k} !== {4'b0000, 4'b1111})
            $display("FAIL reset_jk: got j=%b k=%b expected j=0000 k=1111", j, k);
        else n_pass++;
        step();
        rst = 1'b0;
        #1;
        n_total++;
        if ({q, cmd_if.cmd_ready, busy, done} !== {4'd0, 3'b100})
            $display("FAIL reset_clear: got q=%b r/b/d=%b expected q=0000 100", q, {cmd_if.cmd_ready, busy, done});
        else n_pass++;
    endtask

    task automatic test_up();
        run_cmd(1'b1, 4'd3, 4'd9, -1, -1, 0);
    endtask

    task automatic test_down_wrap();
        run_cmd(1'b0, 4'd1, 4'd14, -1, -1, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            n_total++;
            if ({q, done} !== {4'd14, 1'b0})
                $display("FAIL idle_hold: got q=%0d done=%b expected q=14 done=0", q, done);
            else n_pass++;
        end
    endtask

    task automatic test_equal();
        run_cmd(1'b0, 4'd5, 4'd5, -1, -1, 0);
    endtask

    task automatic test_abort();
        run_cmd(1'b1, 4'd0, 4'd15, 4, -1, 0);
        // abort in IDLE is ignored, and abort alongside a command still accepts it.
        abort            = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_up    = 1'b1;
        cmd_if.cmd_start = 4'd4;
        cmd_if.cmd_limit = 4'd6;
        #1;
        n_total++;
        if (cmd_if.cmd_ready !== 1'b1)
            $display("FAIL abort_idle_ready: got %b expected 1", cmd_if.cmd_ready);
        else n_pass++;
        step();
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL abort_idle_accept: got busy=%b expected 1", busy);
        else n_pass++;
        step();
        step();
        step();
        n_total++;
        if ({q, done} !== {4'd6, 1'b0})
            $display("FAIL post_abort_count: got q=%0d done=%b expected q=6 done=0", q, done);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1)
            $display("FAIL post_abort_done: got %b expected 1", done);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        bit found;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_up    = 1'b1;
        cmd_if.cmd_start = 4'd0;
        cmd_if.cmd_limit = 4'd15;
        step();
        cmd_if.cmd_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (q == 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found)
            $display("FAIL reach_six: got q=%0d expected 6 within 20 cycles", q);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_total++;
        if ({q, busy, cmd_if.cmd_ready} !== {4'd0, 2'b01})
            $display("FAIL mid_reset: got q=%0d busy/ready=%b expected q=0 01", q, {busy, cmd_if.cmd_ready});
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            step();
            n_total++;
            if ({q, done, cmd_if.cmd_ready} !== {4'd0, 2'b01})
                $display("FAIL mid_reset_quiet: got q=%0d done/ready=%b expected q=0 01", q, {done, cmd_if.cmd_ready});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_up    = 1'b1;
        cmd_if.cmd_start = 4'd2;
        cmd_if.cmd_limit = 4'd2;
        step();
        // Second command held by the sender while the first is in flight.
        cmd_if.cmd_start = 4'd9;
        cmd_if.cmd_limit = 4'd9;
        #1;
        n_total++;
        if ({cmd_if.cmd_ready, busy} !== 2'b01)
            $display("FAIL b2b_load: got ready/busy=%b expected 01", {cmd_if.cmd_ready, busy});
        else n_pass++;
        step();
        n_total++;
        if ({q, cmd_if.cmd_ready} !== {4'd2, 1'b0})
            $display("FAIL b2b_run: got q=%0d ready=%b expected q=2 ready=0", q, cmd_if.cmd_ready);
        else n_pass++;
        step();
        n_total++;
        if ({done, cmd_if.cmd_ready} !== 2'b10)
            $display("FAIL b2b_done: got done/ready=%b expected 10", {done, cmd_if.cmd_ready});
        else n_pass++;
        step();
        n_total++;
        if ({cmd_if.cmd_ready, busy} !== 2'b10)
            $display("FAIL b2b_idle: got ready/busy=%b expected 10", {cmd_if.cmd_ready, busy});
        else n_pass++;
        step();
        cmd_if.cmd_valid = 1'b0;
        step();
        n_total++;
        if (q !== 4'd9)
            $display("FAIL b2b_second: got q=%0d expected 9", q);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1)
            $display("FAIL b2b_second_done: got %b expected 1", done);
        else n_pass++;
        step();
    endtask

`ifdef JKC_PAUSE_EN
    task automatic test_pause();
        run_cmd(1'b1, 4'd0, 4'd4, -1, 2, 3);
    endtask
`endif

    task automatic test_random();
        int ak;
        int pk;
        int pl;
        for (int n = 0; n < 12; n++) begin
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            pk = int'($urandom_range(0, 10));
            pl = int'($urandom_range(0, 3));
            run_cmd(1'($urandom), 4'($urandom), 4'($urandom), ak, pk, pl);
            for (int c = 0; c < int'($urandom_range(0, 2)); c++) step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_up();
        test_down_wrap();
        test_equal();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef JKC_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_jk_count_ctrl
`default_nettype wire
